thd_frame_ctrl: RTL and testbench

Frame sequencer for the THD datapath. It gates the incoming sample stream into the 32-deep serial-in/parallel-out buffer, counts one frame of samples, and launches the THD computation engine on the full frame with a start/valid handshake. It then re-arms for the next frame. It sits between the ADC-side sample source (`in_ready`/`d_in`) and the `SIPO` plus THD calculation blocks, and reports frame completion, overrun and timeout status.

---
 rtl/thd_pkg.sv | 12 +
 rtl/thd_frame_ctrl_watchdog.sv | 30 +++
 rtl/thd_frame_ctrl.sv | 114 +++++++++++
 tb/tb_thd_frame_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thd_pkg.sv
// thd_pkg: shared frame geometry and controller state encoding for the THD datapath
package thd_pkg;
   localparam int DW = 16;
   localparam int N_SAMPLES = 32;
   localparam int CW = $clog2(N_SAMPLES);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      LAUNCH  = 2'd2,
      COMPUTE = 2'd3
   } thd_ctrl_state_t;
endpackage

// File: rtl/thd_frame_ctrl_watchdog.sv
// thd_watchdog: up-counter restarted by start, halted by clear, flags the TIMEOUT-1 limit
module thd_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic clear_i,
   output logic expired_o
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
   logic [TW-1:0] cnt_q;
   logic          run_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (clear_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (run_q && cnt_q != LIMIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
   assign expired_o = run_q && cnt_q == LIMIT;
endmodule

// File: rtl/thd_frame_ctrl.sv
// thd_frame_ctrl: gates samples into the SIPO, launches the THD engine per frame, tracks drops and timeouts
module thd_frame_ctrl
   import thd_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic                 clr_flags_i,
   input  logic                 in_ready_i,
   input  logic signed [DW-1:0] d_in_i,
   output logic                 sipo_load_o,
   output logic signed [DW-1:0] sipo_din_o,
   output logic                 sipo_clear_o,
   input  logic                 sipo_done_i,
   output logic                 calc_start_o,
   input  logic                 calc_valid_i,
   output logic                 frame_valid_o,
   output logic [7:0]           frame_count_o,
   output logic [7:0]           drop_count_o,
   output logic                 overrun_o,
   output logic                 timeout_err_o,
   output logic [1:0]           state_o
);
   thd_ctrl_state_t      state_q;
   logic [CW-1:0]        cnt_q;
   logic                 sipo_load_q, sipo_clear_q, calc_start_q, frame_valid_q;
   logic signed [DW-1:0] sipo_din_q;
   logic [7:0]           frame_count_q, drop_count_q, drop_base, drop_count_d;
   logic                 overrun_q, timeout_err_q;
   logic                 drop_now, launch_now, expired, wd_clear;
   assign drop_now   = in_ready_i && (state_q == LAUNCH || state_q == COMPUTE);
   assign launch_now = state_q == LAUNCH && sipo_done_i;
   assign wd_clear   = state_q == COMPUTE && (calc_valid_i || expired);
   // a drop in the clearing cycle still counts, so it lands on a zeroed base
   assign drop_base    = clr_flags_i ? 8'd0 : drop_count_q;
   assign drop_count_d = drop_base + 8'(drop_now && drop_base != 8'hFF);
   thd_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk       (clk),
      .rst       (rst),
      .start_i   (launch_now),
      .clear_i   (wd_clear),
      .expired_o (expired)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         sipo_load_q   <= 1'b0;
         sipo_din_q    <= '0;
         sipo_clear_q  <= 1'b0;
         calc_start_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_count_q <= 8'd0;
         drop_count_q  <= 8'd0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         sipo_load_q   <= 1'b0;
         sipo_clear_q  <= 1'b0;
         calc_start_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         drop_count_q  <= drop_count_d;
         overrun_q     <= drop_now || (overrun_q && !clr_flags_i);
         if (clr_flags_i) timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: if (enable_i) begin
               state_q      <= FILL;
               sipo_clear_q <= 1'b1;
               cnt_q        <= '0;
            end
            FILL: begin
               if (in_ready_i) begin
                  sipo_load_q <= 1'b1;
                  sipo_din_q  <= d_in_i;
                  cnt_q       <= cnt_q + 1'b1;
               end
               if (!enable_i) begin
                  state_q      <= IDLE;
                  sipo_clear_q <= 1'b1;
               end else if (in_ready_i && cnt_q == CW'(N_SAMPLES - 1)) begin
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: if (sipo_done_i) begin
               calc_start_q <= 1'b1;
               state_q      <= COMPUTE;
            end
            COMPUTE: if (calc_valid_i) begin
               frame_valid_q <= 1'b1;
               frame_count_q <= frame_count_q + 8'd1;
               state_q       <= enable_i ? FILL : IDLE;
               sipo_clear_q  <= enable_i;
               cnt_q         <= '0;
            end else if (expired) begin
               timeout_err_q <= 1'b1;
               sipo_clear_q  <= 1'b1;
               state_q       <= IDLE;
            end
         endcase
      end
   end
   assign sipo_load_o   = sipo_load_q;
   assign sipo_din_o    = sipo_din_q;
   assign sipo_clear_o  = sipo_clear_q;
   assign calc_start_o  = calc_start_q;
   assign frame_valid_o = frame_valid_q;
   assign frame_count_o = frame_count_q;
   assign drop_count_o  = drop_count_q;
   assign overrun_o     = overrun_q;
   assign timeout_err_o = timeout_err_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_thd_frame_ctrl.sv
// tb_thd_frame_ctrl: randomized scenarios against a SIPO/engine model and frame-level expectations
module tb_thd_frame_ctrl;
   logic clk = 0, rst = 1, enable = 0, clr_flags = 0, in_ready = 0, calc_valid = 0;
   logic signed [15:0] d_in = 0, sipo_din;
   logic sipo_load, sipo_clear, sipo_done, calc_start, frame_valid, overrun, timeout_err;
   logic [7:0] frame_count, drop_count;
   logic [1:0] state;
   int tests = 0, fails = 0;
   int exp_fc = 0, drops_sent = 0;
   int n_load = 0, n_start = 0, n_fv = 0;
   logic [15:0] mem [32];
   logic [15:0] exp_q [$];
   int scnt = 0;
   bit hold_done = 0;

   always #5 clk = ~clk;

   thd_frame_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .enable_i(enable), .clr_flags_i(clr_flags),
      .in_ready_i(in_ready), .d_in_i(d_in), .sipo_load_o(sipo_load), .sipo_din_o(sipo_din),
      .sipo_clear_o(sipo_clear), .sipo_done_i(sipo_done), .calc_start_o(calc_start),
      .calc_valid_i(calc_valid), .frame_valid_o(frame_valid), .frame_count_o(frame_count),
      .drop_count_o(drop_count), .overrun_o(overrun), .timeout_err_o(timeout_err), .state_o(state)
   );

   // 32-deep SIPO stand-in: collects loaded words, done once full
   always @(posedge clk) begin
      if (rst || sipo_clear) scnt <= 0;
      else if (sipo_load && scnt < 32) begin
         mem[scnt] <= sipo_din;
         scnt <= scnt + 1;
      end
   end
   assign sipo_done = scnt == 32 && !hold_done;

   always @(posedge clk) begin
      #1;
      if (sipo_load) n_load++;
      if (calc_start) n_start++;
      if (frame_valid) n_fv++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   function automatic int frame_bad();
      int b = 0;
      if (exp_q.size() != 32) return 32;
      for (int i = 0; i < 32; i++) if (mem[i] !== exp_q[i]) b++;
      return b;
   endfunction

   function automatic logic [7:0] exp_drop();
      return 8'(drops_sent > 255 ? 255 : drops_sent);
   endfunction

   task automatic send(input logic [15:0] v);
      in_ready = 1;
      d_in = v;
      exp_q.push_back(v);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         in_ready = 0;
         @(negedge clk);
      end
   endtask

   task automatic arm();
      enable = 1;
      idle(1);
   endtask

   task automatic send_frame(input bit gaps, input int base);
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         send(base < 0 ? 16'($urandom) : 16'(base + i));
         if (gaps && i < 31) idle($urandom_range(0, 2));
      end
   endtask

   task automatic wait_start(output int lat);
      lat = 0;
      in_ready = 0;
      while (!calc_start && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (calc_start !== 1'b1) begin
         fails++;
         $display("FAIL calc_start_wait: calc_start=%b after %0d cycles, required 1", calc_start, lat);
      end
   endtask

   task automatic respond(input int lat, input int ndrop);
      for (int j = 0; j < lat; j++) begin
         in_ready = j < ndrop;
         d_in = 16'($urandom);
         calc_valid = 0;
         @(negedge clk);
      end
      in_ready = 0;
      calc_valid = 1;
      @(negedge clk);
      calc_valid = 0;
      drops_sent += ndrop;
      exp_fc = (exp_fc + 1) % 256;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      tests++;
      if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d, required 0", state); end
      tests++;
      if ({sipo_load, sipo_clear, calc_start, frame_valid, overrun, timeout_err} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {sipo_load, sipo_clear, calc_start, frame_valid, overrun, timeout_err});
      end
      tests++;
      if ({frame_count, drop_count, sipo_din} !== 32'd0) begin
         fails++;
         $display("FAIL reset_counts: fc=%0d dc=%0d din=%0h, required all 0", frame_count, drop_count, sipo_din);
      end
      rst = 0;
   endtask

   task automatic test_basic();
      int lat, s0 = n_load, st0 = n_start, f0 = n_fv;
      arm();
      send_frame(1, 1);
      tests++;
      if (state !== 2'd2) begin fails++; $display("FAIL basic_launch_state: got %0d, required 2", state); end
      wait_start(lat);
      tests++;
      if (lat != 2) begin fails++; $display("FAIL basic_start_latency: got %0d, required 2", lat); end
      tests++;
      if (frame_bad() != 0) begin fails++; $display("FAIL basic_frame_data: %0d words wrong, word0 %0h required 1", frame_bad(), mem[0]); end
      respond(10, 0);
      tests++;
      if (frame_valid !== 1'b1 || frame_count !== 8'(exp_fc)) begin
         fails++;
         $display("FAIL basic_frame_valid: fv=%b fc=%0d, required 1 and %0d", frame_valid, frame_count, exp_fc);
      end
      enable = 0;
      idle(1);
      tests++;
      if (frame_valid !== 1'b0) begin fails++; $display("FAIL basic_fv_single: got %b, required 0", frame_valid); end
      idle(2);
      tests++;
      if (n_load - s0 != 32 || n_start - st0 != 1 || n_fv - f0 != 1 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL basic_counts: loads=%0d starts=%0d fv=%0d ovr=%b, required 32 1 1 0",
                  n_load - s0, n_start - st0, n_fv - f0, overrun);
      end
   endtask

   task automatic test_overrun();
      int lat, s0 = n_load;
      arm();
      send_frame(1, -1);
      wait_start(lat);
      respond(8, 5);
      tests++;
      if (drop_count !== exp_drop() || overrun !== 1'b1 || n_load - s0 != 32) begin
         fails++;
         $display("FAIL overrun_drops: dc=%0d ovr=%b loads=%0d, required %0d 1 32", drop_count, overrun, n_load - s0, exp_drop());
      end
      enable = 0;
      idle(2);
      clr_flags = 1;
      idle(1);
      clr_flags = 0;
      drops_sent = 0;
      tests++;
      if (drop_count !== 8'd0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear: dc=%0d ovr=%b, required 0 0", drop_count, overrun);
      end
      hold_done = 1;
      s0 = n_load;
      arm();
      send_frame(0, -1);
      in_ready = 1;
      repeat (260) begin
         d_in = 16'($urandom);
         @(negedge clk);
      end
      drops_sent += 260;
      tests++;
      if (drop_count !== exp_drop() || overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_saturate: dc=%0d ovr=%b, required %0d 1", drop_count, overrun, exp_drop());
      end
      clr_flags = 1;
      @(negedge clk);
      clr_flags = 0;
      in_ready = 0;
      drops_sent = 1;
      tests++;
      if (drop_count !== exp_drop() || overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_clr_vs_drop: dc=%0d ovr=%b, required 1 1", drop_count, overrun);
      end
      clr_flags = 1;
      @(negedge clk);
      clr_flags = 0;
      drops_sent = 0;
      hold_done = 0;
      wait_start(lat);
      tests++;
      if (frame_bad() != 0 || n_load - s0 != 32) begin
         fails++;
         $display("FAIL overrun_no_forward: bad=%0d loads=%0d, required 0 32", frame_bad(), n_load - s0);
      end
      respond(4, 0);
      tests++;
      if (frame_valid !== 1'b1 || frame_count !== 8'(exp_fc) || drop_count !== 8'd0) begin
         fails++;
         $display("FAIL overrun_frame: fv=%b fc=%0d dc=%0d, required 1 %0d 0", frame_valid, frame_count, drop_count, exp_fc);
      end
      enable = 0;
      idle(2);
   endtask

   task automatic test_timeout();
      int lat;
      arm();
      send_frame(1, -1);
      wait_start(lat);
      for (int j = 1; j <= 16; j++) begin
         in_ready = 0;
         @(negedge clk);
         if (j == 15) begin
            tests++;
            if (timeout_err !== 1'b0 || state !== 2'd3) begin
               fails++;
               $display("FAIL timeout_early: terr=%b state=%0d, required 0 3", timeout_err, state);
            end
         end
      end
      tests++;
      if (timeout_err !== 1'b1 || state !== 2'd0 || sipo_clear !== 1'b1 || frame_valid !== 1'b0 || frame_count !== 8'(exp_fc)) begin
         fails++;
         $display("FAIL timeout_fire: terr=%b state=%0d clr=%b fv=%b fc=%0d, required 1 0 1 0 %0d",
                  timeout_err, state, sipo_clear, frame_valid, frame_count, exp_fc);
      end
      enable = 0;
      idle(2);
      clr_flags = 1;
      idle(1);
      clr_flags = 0;
      tests++;
      if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b, required 0", timeout_err); end
   endtask

   task automatic test_abort();
      int lat, s0;
      arm();
      for (int i = 0; i < 10; i++) send(16'($urandom));
      in_ready = 0;
      enable = 0;
      @(negedge clk);
      tests++;
      if (state !== 2'd0 || sipo_clear !== 1'b1) begin
         fails++;
         $display("FAIL abort_idle: state=%0d clr=%b, required 0 1", state, sipo_clear);
      end
      s0 = n_load;
      arm();
      send_frame(1, -1);
      wait_start(lat);
      tests++;
      if (frame_bad() != 0) begin fails++; $display("FAIL abort_frame_data: %0d words wrong, required 0", frame_bad()); end
      respond(6, 0);
      tests++;
      if (frame_valid !== 1'b1 || frame_count !== 8'(exp_fc) || n_load - s0 != 32) begin
         fails++;
         $display("FAIL abort_frame: fv=%b fc=%0d loads=%0d, required 1 %0d 32", frame_valid, frame_count, n_load - s0, exp_fc);
      end
      enable = 0;
      idle(2);
   endtask

   task automatic test_back_to_back();
      int lat;
      arm();
      for (int f = 0; f < 3; f++) begin
         send_frame(0, -1);
         wait_start(lat);
         tests++;
         if (lat != 2 || frame_bad() != 0) begin
            fails++;
            $display("FAIL b2b_frame%0d_data: lat=%0d bad=%0d, required 2 0", f, lat, frame_bad());
         end
         respond(f == 2 ? 15 : $urandom_range(3, 14), 0);
         tests++;
         if (frame_valid !== 1'b1 || timeout_err !== 1'b0 || frame_count !== 8'(exp_fc)) begin
            fails++;
            $display("FAIL b2b_frame%0d_valid: fv=%b terr=%b fc=%0d, required 1 0 %0d", f, frame_valid, timeout_err, frame_count, exp_fc);
         end
      end
      tests++;
      if (drop_count !== 8'd0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL b2b_no_drops: dc=%0d ovr=%b, required 0 0", drop_count, overrun);
      end
      enable = 0;
      idle(2);
   endtask

   task automatic test_reset_compute();
      int lat;
      arm();
      send_frame(0, -1);
      wait_start(lat);
      idle(3);
      rst = 1;
      @(negedge clk);
      rst = 0;
      enable = 0;
      exp_fc = 0;
      tests++;
      if (state !== 2'd0 || {sipo_load, sipo_clear, calc_start, frame_valid, overrun, timeout_err} !== 6'b0 || frame_count !== 8'd0 || drop_count !== 8'd0) begin
         fails++;
         $display("FAIL rst_compute: state=%0d flags=%b fc=%0d dc=%0d, required 0 000000 0 0",
                  state, {sipo_load, sipo_clear, calc_start, frame_valid, overrun, timeout_err}, frame_count, drop_count);
      end
      calc_valid = 1;
      @(negedge clk);
      calc_valid = 0;
      @(negedge clk);
      tests++;
      if (frame_valid !== 1'b0 || frame_count !== 8'(exp_fc) || state !== 2'd0) begin
         fails++;
         $display("FAIL rst_late_valid: fv=%b fc=%0d state=%0d, required 0 0 0", frame_valid, frame_count, state);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_timeout();
      test_abort();
      test_back_to_back();
      test_reset_compute();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
